// File: rtl/robot_pkg.sv
// Shared types for the robot navigation controller: motor command encoding,
// controller states and the camera zone decoder.
package robot_pkg;

    typedef enum logic [4:0] {
        MOT_STOP  = 5'b00001,
        MOT_FWD   = 5'b00010,
        MOT_RIGHT = 5'b00100,
        MOT_LEFT  = 5'b01000,
        MOT_SPIN  = 5'b10000
    } motor_e;

    // Encoding order matches the state_onehot bit order.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SEARCH   = 4'd1,
        ST_FORWARD  = 4'd2,
        ST_LEFT     = 4'd3,
        ST_RIGHT    = 4'd4,
        ST_STOP     = 4'd5,
        ST_ARRIVED  = 4'd6,
        ST_WAIT_ACK = 4'd7,
        ST_REARM    = 4'd8,
        ST_LOST     = 4'd9
    } nav_state_e;

    typedef enum logic [1:0] {
        DIR_NONE   = 2'd0,
        DIR_CENTRE = 2'd1,
        DIR_LEFT   = 2'd2,
        DIR_RIGHT  = 2'd3
    } zone_dir_e;

    typedef struct packed {
        zone_dir_e   dir;
        int unsigned mag;
    } zone_info_t;

    localparam int MAX_ZONES = 15;

    // Zone vector is zero-extended to MAX_ZONES; anything but a single set bit is "none".
    function automatic zone_info_t zone_decode(input logic [MAX_ZONES-1:0] z, input int zones);
        zone_info_t r;
        int cnt;
        int idx;
        int c;
        r.dir = DIR_NONE;
        r.mag = 0;
        cnt   = 0;
        idx   = 0;
        c     = (zones - 1) / 2;
        for (int i = 0; i < MAX_ZONES; i++) begin
            if (z[i]) begin
                cnt = cnt + 1;
                idx = i;
            end
        end
        if (cnt == 1) begin
            if (idx == c) begin
                r.dir = DIR_CENTRE;
            end else if (idx > c) begin
                r.dir = DIR_LEFT;
                r.mag = idx - c;
            end else begin
                r.dir = DIR_RIGHT;
                r.mag = c - idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Decision tick generator: down-counter that pulses tick for one clk
// every TICK_CYCLES clks, starting on the first clk after reset.
module tick_gen #(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= CW'(TICK_CYCLES - 1);
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/robot_nav_fsm.sv
// Summon-and-follow navigation controller: seeks a camera target, approaches
// it, waits for operator acknowledge, and gives up after a search timeout.
//
// state    | meaning
// IDLE     | parked, waiting for bell
// SEARCH   | spinning, looking for a valid zone
// FORWARD  | target centred, driving straight
// LEFT     | target left of centre, turning left
// RIGHT    | target right of centre, turning right
// STOP     | proximity asserted, halted
// ARRIVED  | target reached (one tick)
// WAIT_ACK | waiting for operator button or re-summon
// REARM    | re-arm pulse (one tick) before searching again
// LOST     | search timed out, waiting for button
module robot_nav_fsm
    import robot_pkg::*;
#(
    parameter int ZONES          = 5,
    parameter int TICK_CYCLES    = 50000000,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int SEARCH_TIMEOUT = 30
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bell,
    input  logic                          proximity,
    input  logic [ZONES-1:0]              zone,
    input  logic                          button1,
    output logic [4:0]                    motor_cmd,
    output logic [$clog2(ZONES/2+1)-1:0]  steer_level,
    output logic                          overwrite,
    output logic                          lost,
    output logic [9:0]                    state_onehot
);

    localparam int SW = $clog2(ZONES / 2 + 1);

    logic       tick;
    nav_state_e state;
    nav_state_e state_nxt;
    nav_state_e zone_target;
    zone_info_t zi;
    logic       prox_db;
    logic       prox_new;
    logic [3:0] db_cnt;
    logic [4:0] db_inc;
    logic       db_flip;
    logic [7:0] srch_cnt;
    logic [7:0] srch_inc;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign zi       = zone_decode(MAX_ZONES'(zone), ZONES);
    assign srch_inc = srch_cnt + 8'd1;
    assign db_inc   = {1'b0, db_cnt} + 5'd1;
    assign db_flip  = (proximity != prox_db) && (db_inc >= 5'(DEBOUNCE_TICKS));
    // The FSM reacts on the same tick the debounced value settles.
    assign prox_new = db_flip ? proximity : prox_db;

    always_comb begin
        zone_target = ST_SEARCH;
        case (zi.dir)
            DIR_CENTRE: zone_target = ST_FORWARD;
            DIR_LEFT:   zone_target = ST_LEFT;
            DIR_RIGHT:  zone_target = ST_RIGHT;
            default:    zone_target = ST_SEARCH;
        endcase
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:     state_nxt = bell ? ST_SEARCH : ST_IDLE;
            ST_SEARCH: begin
                if (zi.dir != DIR_NONE) begin
                    state_nxt = zone_target;
                end else if (srch_inc >= 8'(SEARCH_TIMEOUT)) begin
                    state_nxt = ST_LOST;
                end else begin
                    state_nxt = ST_SEARCH;
                end
            end
            ST_FORWARD, ST_LEFT, ST_RIGHT:
                state_nxt = prox_new ? ST_STOP : zone_target;
            ST_STOP: begin
                if (!prox_new) begin
                    state_nxt = ST_SEARCH;
                end else if (zi.dir == DIR_CENTRE) begin
                    state_nxt = ST_ARRIVED;
                end else begin
                    state_nxt = ST_STOP;
                end
            end
            ST_ARRIVED:  state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: state_nxt = button1 ? ST_IDLE : (bell ? ST_REARM : ST_WAIT_ACK);
            ST_REARM:    state_nxt = ST_SEARCH;
            ST_LOST:     state_nxt = button1 ? ST_IDLE : ST_LOST;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            prox_db      <= 1'b0;
            db_cnt       <= '0;
            srch_cnt     <= '0;
            motor_cmd    <= MOT_STOP;
            steer_level  <= '0;
            overwrite    <= 1'b0;
            lost         <= 1'b0;
            state_onehot <= 10'b0000000001;
        end else if (tick) begin
            state   <= state_nxt;
            prox_db <= prox_new;
            if (proximity == prox_db || db_flip) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_inc[3:0];
            end
            srch_cnt <= (state == ST_SEARCH && state_nxt == ST_SEARCH) ? srch_inc : 8'd0;
            case (state_nxt)
                ST_SEARCH:  motor_cmd <= MOT_SPIN;
                ST_FORWARD: motor_cmd <= MOT_FWD;
                ST_LEFT:    motor_cmd <= MOT_LEFT;
                ST_RIGHT:   motor_cmd <= MOT_RIGHT;
                default:    motor_cmd <= MOT_STOP;
            endcase
            steer_level  <= (state_nxt == ST_LEFT || state_nxt == ST_RIGHT) ? SW'(zi.mag) : '0;
            overwrite    <= (state_nxt == ST_REARM);
            lost         <= (state_nxt == ST_LOST);
            state_onehot <= 10'b0000000001 << state_nxt;
        end
    end

endmodule

// File: tb/tb_robot_nav_fsm.sv
// Bench for robot_nav_fsm: directed scenario walk followed by randomized
// inputs, every clk compared against a tick-level behavioural model.
module tb_robot_nav_fsm;

    localparam int ZONES = 5;
    localparam int TICK  = 4;
    localparam int DB    = 2;
    localparam int TO    = 3;
    localparam int CTR   = (ZONES - 1) / 2;

    localparam int S_IDLE = 0, S_SEARCH = 1, S_FWD = 2, S_LEFT = 3, S_RIGHT = 4;
    localparam int S_STOP = 5, S_ARR = 6, S_WAIT = 7, S_REARM = 8, S_LOST = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             bell = 1'b0;
    logic             proximity = 1'b0;
    logic             button1 = 1'b0;
    logic [ZONES-1:0] zone = '0;
    logic [4:0]       motor_cmd;
    logic [1:0]       steer_level;
    logic             overwrite;
    logic             lost;
    logic [9:0]       state_onehot;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_state = S_IDLE;
    int m_prox  = 0;
    int m_run   = 0;
    int m_secs  = 0;
    int m_steer = 0;
    int m_phase = 0;
    bit m_tick  = 0;

    robot_nav_fsm #(
        .ZONES(ZONES), .TICK_CYCLES(TICK), .DEBOUNCE_TICKS(DB), .SEARCH_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .bell(bell), .proximity(proximity), .zone(zone),
        .button1(button1), .motor_cmd(motor_cmd), .steer_level(steer_level),
        .overwrite(overwrite), .lost(lost), .state_onehot(state_onehot)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] motor_for(int s);
        if (s == S_SEARCH) return 5'b10000;
        if (s == S_FWD)    return 5'b00010;
        if (s == S_LEFT)   return 5'b01000;
        if (s == S_RIGHT)  return 5'b00100;
        return 5'b00001;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clk edge using the inputs currently applied.
    task automatic model_edge();
        int n, idx, side, target, ns;
        m_tick = 0;
        if (reset) begin
            m_state = S_IDLE; m_prox = 0; m_run = 0; m_secs = 0; m_steer = 0; m_phase = 0;
            return;
        end
        m_tick  = (m_phase == 0);
        m_phase = (m_phase + 1) % TICK;
        if (!m_tick) return;
        if (int'(proximity) != m_prox) begin
            m_run++;
            if (m_run >= DB) begin m_prox = int'(proximity); m_run = 0; end
        end else begin
            m_run = 0;
        end
        n = $countones(zone);
        idx = (n == 1) ? $clog2(zone) : -1;
        side = idx - CTR;
        if (n != 1)        target = S_SEARCH;
        else if (side == 0) target = S_FWD;
        else if (side > 0)  target = S_LEFT;
        else                target = S_RIGHT;
        ns = m_state;
        case (m_state)
            S_IDLE:   if (bell) ns = S_SEARCH;
            S_SEARCH: begin
                if (n == 1) ns = target;
                else begin
                    m_secs++;
                    ns = (m_secs >= TO) ? S_LOST : S_SEARCH;
                end
            end
            S_FWD, S_LEFT, S_RIGHT: ns = m_prox ? S_STOP : target;
            S_STOP:   if (!m_prox) ns = S_SEARCH; else if (n == 1 && side == 0) ns = S_ARR;
            S_ARR:    ns = S_WAIT;
            S_WAIT:   if (button1) ns = S_IDLE; else if (bell) ns = S_REARM;
            S_REARM:  ns = S_SEARCH;
            S_LOST:   if (button1) ns = S_IDLE;
            default:  ns = S_IDLE;
        endcase
        if (ns != S_SEARCH || m_state != S_SEARCH) m_secs = 0;
        m_steer = (ns == S_LEFT || ns == S_RIGHT) ? ((side < 0) ? -side : side) : 0;
        m_state = ns;
    endtask

    task automatic cycle();
        logic [18:0] exp_v;
        model_edge();
        @(posedge clk);
        #1;
        exp_v = {motor_for(m_state), 2'(m_steer), 1'(m_state == S_REARM),
                 1'(m_state == S_LOST), 10'(1 << m_state)};
        check("model_outputs", {13'd0, motor_cmd, steer_level, overwrite, lost, state_onehot},
              {13'd0, exp_v});
    endtask

    task automatic do_tick();
        bit got = 0;
        for (int i = 0; i < 2 * TICK && !got; i++) begin
            cycle();
            got = m_tick;
        end
        check("tick_seen", 32'(got), 32'd1);
    endtask

    task automatic expect_state(string tag, int s);
        check(tag, 32'(state_onehot), 32'(1 << s));
    endtask

    initial begin
        repeat (3) cycle();
        reset = 1'b0;
        check("reset_motor", 32'(motor_cmd), 32'h01);
        check("reset_onehot", 32'(state_onehot), 32'h001);

        bell = 1'b1;
        do_tick();
        expect_state("bell_to_search", S_SEARCH);
        check("search_spin", 32'(motor_cmd), 32'h10);
        bell = 1'b0; zone = 5'b10000;
        do_tick();
        expect_state("far_left", S_LEFT);
        check("far_left_steer", 32'(steer_level), 32'd2);
        zone = 5'b00100;
        do_tick();
        expect_state("centre_fwd", S_FWD);
        check("centre_steer", 32'(steer_level), 32'd0);
        zone = 5'b00011;
        do_tick();
        expect_state("multi_zone_search", S_SEARCH);

        zone = 5'b00100;
        do_tick();
        proximity = 1'b1;
        do_tick();
        proximity = 1'b0;
        do_tick();
        expect_state("prox_pulse_ignored", S_FWD);
        proximity = 1'b1;
        do_tick();
        do_tick();
        expect_state("prox_held_stop", S_STOP);
        do_tick();
        expect_state("arrived", S_ARR);
        do_tick();
        expect_state("wait_ack", S_WAIT);

        bell = 1'b1;
        do_tick();
        expect_state("rearm", S_REARM);
        check("rearm_overwrite", 32'(overwrite), 32'd1);
        bell = 1'b0;
        do_tick();
        expect_state("rearm_to_search", S_SEARCH);
        check("overwrite_one_tick", 32'(overwrite), 32'd0);
        repeat (4) do_tick();
        expect_state("back_to_wait", S_WAIT);
        bell = 1'b1; button1 = 1'b1;
        do_tick();
        expect_state("button_wins", S_IDLE);

        button1 = 1'b0; proximity = 1'b0; zone = '0;
        do_tick();
        bell = 1'b0;
        repeat (3) do_tick();
        expect_state("timeout_lost", S_LOST);
        check("lost_flag", 32'(lost), 32'd1);
        check("lost_motor", 32'(motor_cmd), 32'h01);
        bell = 1'b1;
        do_tick();
        expect_state("lost_ignores_bell", S_LOST);
        bell = 1'b0; button1 = 1'b1;
        do_tick();
        expect_state("lost_button", S_IDLE);

        button1 = 1'b0; bell = 1'b1;
        do_tick();
        bell = 1'b0; zone = 5'b00001;
        do_tick();
        expect_state("far_right", S_RIGHT);
        check("far_right_steer", 32'(steer_level), 32'd2);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check("midrun_reset", {13'd0, motor_cmd, steer_level, overwrite, lost, state_onehot},
              {13'd0, 5'b00001, 2'd0, 1'b0, 1'b0, 10'b0000000001});
        reset = 1'b0;

        for (int n = 0; n < 2000; n++) begin
            bell    = ($urandom_range(0, 5) == 0);
            button1 = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 5) == 0) proximity = ~proximity;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:    zone = '0;
                    2:       zone = ZONES'($urandom);
                    default: zone = ZONES'(1 << $urandom_range(0, ZONES - 1));
                endcase
            end
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
